puf_auth_ctrl: RTL and testbench

Challenge-response controller that sits on the host side of the Ring_Oscillator_PUF port set (en, rst, chall_in, response, ready). It drives challenges into the PUF, pulses the PUF reset, waits for ready with a timeout, and captures the response. In enroll mode it stores the challenge/response pair (CRP) in an internal table. In authenticate mode it replays a stored challenge and grades the fresh response by Hamming distance against the enrolled one.

---
 rtl/puf_auth_ctrl_if.sv | 33 +++
 rtl/puf_auth_ctrl.sv | 246 ++++++++++++++++++++++++
 tb/tb_puf_auth_ctrl.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/puf_auth_ctrl_if.sv
// PUF-side bus of the authentication controller.
// Signals mirror the Ring_Oscillator_PUF port set:
//   puf_en       PUF enable
//   puf_rst      active-high PUF reset pulse
//   puf_chall    challenge presented to the PUF
//   puf_response PUF response
//   puf_ready    PUF response valid
// Modports:
//   master  controller side (drives en/rst/chall, reads response/ready)
//   slave   PUF side
interface puf_auth_ctrl_if;
    logic       puf_en;
    logic       puf_rst;
    logic [7:0] puf_chall;
    logic [7:0] puf_response;
    logic       puf_ready;

    modport master (
        output puf_en,
        output puf_rst,
        output puf_chall,
        input  puf_response,
        input  puf_ready
    );

    modport slave (
        input  puf_en,
        input  puf_rst,
        input  puf_chall,
        output puf_response,
        output puf_ready
    );
endinterface

// File: rtl/puf_auth_ctrl.sv
// Challenge-response controller for a ring-oscillator PUF.
// Enroll stores a challenge/response pair in an internal table; authenticate
// replays the stored challenge and grades the fresh response by Hamming
// distance against the enrolled one.
//
// Build option: define PUF_AUTH_VOTE_EN to run VOTES evaluations per
// operation and take the per-bit majority; otherwise one evaluation is used.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   start        one-cycle request, sampled only in idle
//   enroll       1 = enroll, 0 = authenticate (sampled with start)
//   crp_idx      table entry (sampled with start)
//   chall_in     challenge for enroll (sampled with start)
//   puf          PUF bus (master modport)
//   busy         operation in progress
//   done         one-cycle completion pulse
//   pass         authentication result, held until next start
//   hd           Hamming distance 0..8, held until next start
//   timeout_err  PUF never became ready, held until next start
module puf_auth_ctrl #(
    parameter int unsigned NUM_CRP   = 8,
    parameter int unsigned TIMEOUT   = 64,
    parameter int unsigned HD_THRESH = 1,
    parameter int unsigned VOTES     = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       enroll,
    input  logic [$clog2(NUM_CRP)-1:0] crp_idx,
    input  logic [7:0]                 chall_in,
    puf_auth_ctrl_if.master            puf,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic [3:0]                 hd,
    output logic                       timeout_err
);

    localparam int unsigned IdxW = $clog2(NUM_CRP);
    localparam int unsigned TmoW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);

    if ((VOTES % 2) == 0 || VOTES < 1) begin : g_bad_votes
        $error("VOTES must be odd and at least 1");
    end

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StPrst,
        StEval,
        StCapture,
        StGrade,
        StFin
    } state_e;

    state_e state_q;

    logic            enroll_q;
    logic [IdxW-1:0] idx_q;
    logic [7:0]      chall_q;
    logic [TmoW-1:0] tmo_cnt_q;
    logic [NUM_CRP-1:0] valid_q;

    // Table contents carry no reset; only the valid bits matter after reset.
    logic [7:0] chall_tab [NUM_CRP];
    logic [7:0] resp_tab  [NUM_CRP];

    logic [7:0] result;
    logic       last_round;
    logic [3:0] auth_hd;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

`ifdef PUF_AUTH_VOTE_EN
    localparam int unsigned CntW = $clog2(VOTES + 1);
    localparam int unsigned RndW = (VOTES > 1) ? $clog2(VOTES) : 1;

    logic [CntW-1:0] vote_cnt_q [8];
    logic [RndW-1:0] round_q;

    // Bit is 1 when it was 1 in a strict majority of the rounds.
    always_comb begin
        result = '0;
        for (int b = 0; b < 8; b++) begin
            result[b] = (32'(vote_cnt_q[b]) > (VOTES / 2));
        end
    end

    assign last_round = (round_q == RndW'(VOTES - 1));
`else
    logic [7:0] cap_q;

    assign result     = cap_q;
    assign last_round = 1'b1;
`endif

    assign auth_hd = popcount8(result ^ resp_tab[idx_q]);

    // Table write happens in GRADE of an enroll; overwrites any old entry.
    always_ff @(posedge clk) begin
        if (state_q == StGrade && enroll_q) begin
            chall_tab[idx_q] <= chall_q;
            resp_tab[idx_q]  <= result;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StIdle;
            enroll_q      <= 1'b0;
            idx_q         <= '0;
            chall_q       <= '0;
            tmo_cnt_q     <= '0;
            valid_q       <= '0;
            puf.puf_en    <= 1'b0;
            puf.puf_rst   <= 1'b0;
            puf.puf_chall <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            hd            <= '0;
            timeout_err   <= 1'b0;
`ifdef PUF_AUTH_VOTE_EN
            round_q       <= '0;
            for (int b = 0; b < 8; b++) begin
                vote_cnt_q[b] <= '0;
            end
`else
            cap_q         <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    done <= 1'b0;
                    if (start) begin
                        enroll_q <= enroll;
                        idx_q    <= crp_idx;
                        chall_q  <= chall_in;
                        busy     <= 1'b1;
                        state_q  <= StLoad;
                    end
                end

                StLoad: begin
                    pass        <= 1'b0;
                    hd          <= '0;
                    timeout_err <= 1'b0;
                    if (!enroll_q && !valid_q[idx_q]) begin
                        // Nothing enrolled here: fail without touching the PUF.
                        hd      <= 4'd8;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= StFin;
                    end else begin
                        puf.puf_chall <= enroll_q ? chall_q : chall_tab[idx_q];
                        puf.puf_en    <= 1'b1;
                        puf.puf_rst   <= 1'b1;
`ifdef PUF_AUTH_VOTE_EN
                        round_q <= '0;
                        for (int b = 0; b < 8; b++) begin
                            vote_cnt_q[b] <= '0;
                        end
`endif
                        state_q <= StPrst;
                    end
                end

                StPrst: begin
                    puf.puf_rst <= 1'b0;
                    tmo_cnt_q   <= '0;
                    state_q     <= StEval;
                end

                StEval: begin
                    if (puf.puf_ready) begin
                        state_q <= StCapture;
                    end else if (tmo_cnt_q == TmoLast) begin
                        // A timeout in any round aborts the whole operation.
                        timeout_err <= 1'b1;
                        pass        <= 1'b0;
                        hd          <= '0;
                        puf.puf_en  <= 1'b0;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        state_q     <= StFin;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
                    end
                end

                StCapture: begin
`ifdef PUF_AUTH_VOTE_EN
                    for (int b = 0; b < 8; b++) begin
                        vote_cnt_q[b] <= vote_cnt_q[b] + CntW'(puf.puf_response[b]);
                    end
`else
                    cap_q <= puf.puf_response;
`endif
                    if (last_round) begin
                        puf.puf_en <= 1'b0;
                        state_q    <= StGrade;
                    end else begin
`ifdef PUF_AUTH_VOTE_EN
                        round_q <= round_q + RndW'(1);
`endif
                        puf.puf_rst <= 1'b1;
                        state_q     <= StPrst;
                    end
                end

                StGrade: begin
                    if (enroll_q) begin
                        valid_q[idx_q] <= 1'b1;
                        pass           <= 1'b1;
                        hd             <= '0;
                    end else begin
                        hd   <= auth_hd;
                        pass <= (32'(auth_hd) <= HD_THRESH);
                    end
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    state_q <= StFin;
                end

                StFin: begin
                    done    <= 1'b0;
                    state_q <= StIdle;
                end

                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_puf_auth_ctrl.sv
// Directed bench for puf_auth_ctrl with a small registered PUF model.
// The model raises ready one cycle after the PUF reset pulse ends and returns
// the next entry of model_resp for each evaluation of an operation.
module tb_puf_auth_ctrl;

    localparam int unsigned NumCrp  = 8;
    localparam int unsigned Timeout = 64;
`ifdef PUF_AUTH_VOTE_EN
    localparam int unsigned Votes = 3;
`else
    localparam int unsigned Votes = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       enroll = 1'b0;
    logic [2:0] crp_idx = '0;
    logic [7:0] chall_in = '0;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] hd;
    logic       timeout_err;

    puf_auth_ctrl_if pif ();

    puf_auth_ctrl #(
        .NUM_CRP   (NumCrp),
        .TIMEOUT   (Timeout),
        .HD_THRESH (1),
        .VOTES     (3)
    ) dut (
        .clk         (clk),
        .rst         (rst_n),
        .start       (start),
        .enroll      (enroll),
        .crp_idx     (crp_idx),
        .chall_in    (chall_in),
        .puf         (pif.master),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .hd          (hd),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // PUF model
    logic [7:0] model_resp [3];
    logic       model_hang = 1'b0;
    int         model_rnd;

    always @(posedge clk) begin
        if (!pif.puf_en) begin
            pif.puf_ready <= 1'b0;
            model_rnd     <= 0;
        end else if (pif.puf_rst) begin
            pif.puf_ready <= 1'b0;
        end else if (!pif.puf_ready && !model_hang) begin
            pif.puf_ready    <= 1'b1;
            pif.puf_response <= model_resp[model_rnd];
            model_rnd        <= model_rnd + 1;
        end
    end

    initial begin
        pif.puf_ready    = 1'b0;
        pif.puf_response = '0;
    end

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Results of the last run_op
    int         done_cyc;
    int         rst_cnt;
    logic [7:0] chall_seen;
    logic       busy_seen;

    task automatic set_model(input logic [7:0] r0, input logic [7:0] r1, input logic [7:0] r2);
        model_resp[0] = r0;
        model_resp[1] = r1;
        model_resp[2] = r2;
    endtask

    // Issue one operation and wait (bounded) for done; cycle 1 is LOAD.
    task automatic run_op(input logic en, input logic [2:0] idx, input logic [7:0] ch);
        @(negedge clk);
        start    = 1'b1;
        enroll   = en;
        crp_idx  = idx;
        chall_in = ch;
        @(negedge clk);
        start      = 1'b0;
        done_cyc   = 0;
        rst_cnt    = 0;
        chall_seen = '0;
        busy_seen  = busy;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            if (pif.puf_rst) begin
                rst_cnt++;
                chall_seen = pif.puf_chall;
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
            @(negedge clk);
        end
        check_eq("done_seen", 32'(done_cyc != 0), 1);
        check_eq("busy_low_at_done", 32'(busy), 0);
    endtask

    initial begin
        set_model(8'h5A, 8'h5A, 8'h5A);
        repeat (3) @(negedge clk);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_pass", 32'(pass), 0);
        check_eq("rst_hd", 32'(hd), 0);
        check_eq("rst_tmo", 32'(timeout_err), 0);
        check_eq("rst_puf_en", 32'(pif.puf_en), 0);
        check_eq("rst_puf_rst", 32'(pif.puf_rst), 0);
        check_eq("rst_puf_chall", 32'(pif.puf_chall), 0);
        rst_n = 1'b1;

        // Enroll idx 2: one reset pulse per round, 4 extra cycles per extra round
        run_op(1'b1, 3'd2, 8'hD4);
        check_eq("enr_busy_after_start", 32'(busy_seen), 1);
        check_eq("enr_done_cyc", 32'(done_cyc), 32'(7 + 4 * (Votes - 1)));
        check_eq("enr_pass", 32'(pass), 1);
        check_eq("enr_hd", 32'(hd), 0);
        check_eq("enr_tmo", 32'(timeout_err), 0);
        check_eq("enr_chall", 32'(chall_seen), 32'h D4);
        check_eq("enr_rst_pulses", 32'(rst_cnt), 32'(Votes));
        @(negedge clk);
        check_eq("enr_done_one_cycle", 32'(done), 0);
        check_eq("enr_chall_held", 32'(pif.puf_chall), 32'h D4);

        // 0x5A vs 0x5B: one bit differs -> pass
        set_model(8'h5B, 8'h5B, 8'h5B);
        run_op(1'b0, 3'd2, 8'h00);
        check_eq("auth1_chall", 32'(chall_seen), 32'h D4);
        check_eq("auth1_hd", 32'(hd), 1);
        check_eq("auth1_pass", 32'(pass), 1);

        // 0x5A vs 0x0F: xor 0x55 -> 4 bits
        set_model(8'h0F, 8'h0F, 8'h0F);
        run_op(1'b0, 3'd2, 8'h00);
        check_eq("auth4_hd", 32'(hd), 4);
        check_eq("auth4_pass", 32'(pass), 0);
        repeat (2) @(negedge clk);
        check_eq("auth4_hd_held", 32'(hd), 4);

        // Never enrolled entry
        run_op(1'b0, 3'd5, 8'h00);
        check_eq("inv_done_cyc", 32'(done_cyc), 2);
        check_eq("inv_hd", 32'(hd), 8);
        check_eq("inv_pass", 32'(pass), 0);
        check_eq("inv_no_puf_rst", 32'(rst_cnt), 0);

        // PUF never ready: reset pulse in cycle 2, Timeout EVAL cycles, then FIN
        model_hang = 1'b1;
        run_op(1'b0, 3'd2, 8'h00);
        check_eq("tmo_done_cyc", 32'(done_cyc), 32'(Timeout + 3));
        check_eq("tmo_err", 32'(timeout_err), 1);
        check_eq("tmo_pass", 32'(pass), 0);
        check_eq("tmo_hd", 32'(hd), 0);
        check_eq("tmo_puf_en", 32'(pif.puf_en), 0);
        model_hang = 1'b0;

        // Entry 2 is untouched by the timed-out operation
        set_model(8'h5A, 8'h5A, 8'h5A);
        run_op(1'b0, 3'd2, 8'h00);
        check_eq("post_tmo_hd", 32'(hd), 0);
        check_eq("post_tmo_pass", 32'(pass), 1);
        check_eq("post_tmo_err_clr", 32'(timeout_err), 0);

`ifdef PUF_AUTH_VOTE_EN
        // Majority of 5A, FF, 5A is 5A
        set_model(8'h5A, 8'hFF, 8'h5A);
        run_op(1'b1, 3'd1, 8'h33);
        check_eq("vote_enr_pass", 32'(pass), 1);
        set_model(8'h5A, 8'h5A, 8'h5A);
        run_op(1'b0, 3'd1, 8'h00);
        check_eq("vote_auth_chall", 32'(chall_seen), 32'h 33);
        check_eq("vote_auth_hd", 32'(hd), 0);
        // 0xFF vs 0x5A: xor 0xA5 -> 4 bits
        set_model(8'hFF, 8'hFF, 8'hFF);
        run_op(1'b0, 3'd1, 8'h00);
        check_eq("vote_auth_ff_hd", 32'(hd), 4);
`endif

        // Reset in the middle of an enroll of idx 4
        set_model(8'h11, 8'h11, 8'h11);
        model_hang = 1'b1;
        @(negedge clk);
        start    = 1'b1;
        enroll   = 1'b1;
        crp_idx  = 3'd4;
        chall_in = 8'hC3;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("mid_in_eval_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_busy", 32'(busy), 0);
        check_eq("mid_rst_puf_en", 32'(pif.puf_en), 0);
        check_eq("mid_rst_puf_chall", 32'(pif.puf_chall), 0);
        check_eq("mid_rst_pass", 32'(pass), 0);
        begin
            logic done_any;
            done_any = 1'b0;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                done_any = done_any | done;
            end
            rst_n = 1'b1;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                done_any = done_any | done;
            end
            check_eq("mid_rst_no_done", 32'(done_any), 0);
        end
        model_hang = 1'b0;

        run_op(1'b0, 3'd4, 8'h00);
        check_eq("after_rst_idx4_hd", 32'(hd), 8);
        check_eq("after_rst_idx4_pass", 32'(pass), 0);
        check_eq("after_rst_idx4_no_rst", 32'(rst_cnt), 0);
        run_op(1'b0, 3'd2, 8'h00);
        check_eq("after_rst_idx2_hd", 32'(hd), 8);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
